// File: rtl/dense_pkg.sv
// dense_pkg: shared constants, FP32 field masks and argmax state type for the dense classifier.
package dense_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int BIAS       = 128;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_e;

    localparam int    FP32_SIGN     = 31;
    localparam fp32_t FP32_EXP_MASK = 32'h7F80_0000;
    localparam fp32_t FP32_MAN_MASK = 32'h007F_FFFF;
endpackage

// File: rtl/fp32_order_key.sv
// fp32_order_key: maps FP32 bits to an unsigned key whose integer order matches float order.
// Both zeros collapse to one key and NaN sinks below every real value.
module fp32_order_key
    import dense_pkg::*;
(
    input  fp32_t       i_x,
    output logic [31:0] o_key
);
    logic w_zero;
    logic w_nan;

    assign w_zero = (i_x & (FP32_EXP_MASK | FP32_MAN_MASK)) == '0;
    assign w_nan  = ((i_x & FP32_EXP_MASK) == FP32_EXP_MASK) && ((i_x & FP32_MAN_MASK) != '0);
    assign o_key  = w_nan           ? 32'h0000_0000 :
                    w_zero          ? 32'h8000_0000 :
                    i_x[FP32_SIGN]  ? ~i_x          :
                                      (i_x | 32'h8000_0000);
endmodule

// File: rtl/dense_argmax.sv
// dense_argmax: serial argmax over a packed FP32 score vector, one compare per cycle.
// Result registers are separate from the running best so outputs hold through the next scan.
module dense_argmax
    import dense_pkg::*;
#(
    parameter int BIAS       = dense_pkg::BIAS,
    parameter int DATA_WIDTH = dense_pkg::DATA_WIDTH,
    parameter int IDX_W      = (BIAS > 1) ? $clog2(BIAS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_WIDTH*BIAS-1:0] data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [IDX_W-1:0]           class_o,
    output logic [DATA_WIDTH-1:0]      max_o
);
    argmax_state_e               r_state;
    argmax_state_e               w_state_nxt;
    logic [DATA_WIDTH*BIAS-1:0]  r_vec;
    logic [DATA_WIDTH-1:0]       r_best;
    logic [IDX_W-1:0]            r_idx;
    logic [IDX_W-1:0]            r_cnt;
    logic [IDX_W-1:0]            r_class;
    logic [DATA_WIDTH-1:0]       r_max;
    logic [DATA_WIDTH-1:0]       w_elem;
    logic [31:0]                 w_key_elem;
    logic [31:0]                 w_key_best;
    logic                        w_gt;
    logic                        w_last;
    logic                        w_accept;
    logic [DATA_WIDTH-1:0]       w_best_nxt;
    logic [IDX_W-1:0]            w_idx_nxt;

    assign w_elem     = r_vec[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_gt       = w_key_elem > w_key_best;
    assign w_last     = r_cnt == IDX_W'(BIAS - 1);
    assign w_accept   = (r_state == IDLE) && valid_i;
    assign w_best_nxt = w_gt ? w_elem : r_best;
    assign w_idx_nxt  = w_gt ? r_cnt : r_idx;

    fp32_order_key u_key_elem (.i_x(w_elem), .o_key(w_key_elem));
    fp32_order_key u_key_best (.i_x(r_best), .o_key(w_key_best));

    always_ff @(posedge clk) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (valid_i ? ((BIAS > 1) ? SCAN : DONE) : IDLE) :
                      (r_state == SCAN) ? (w_last ? DONE : SCAN) :
                                          (ready_i ? IDLE : DONE);
    end

    always_comb begin
        ready_o = r_state == IDLE;
        valid_o = r_state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_vec   <= '0;
            r_best  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_class <= '0;
            r_max   <= '0;
        end else if (w_accept) begin
            r_vec  <= data_i;
            r_best <= data_i[DATA_WIDTH-1:0];
            r_idx  <= '0;
            r_cnt  <= IDX_W'(BIAS > 1);
            if (BIAS == 1) begin
                r_class <= '0;
                r_max   <= data_i[DATA_WIDTH-1:0];
            end
        end else if (r_state == SCAN) begin
            r_best <= w_best_nxt;
            r_idx  <= w_idx_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_class <= w_idx_nxt;
                r_max   <= w_best_nxt;
            end
        end
    end

    assign class_o = r_class;
    assign max_o   = r_max;
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: directed vectors against a 128-class and a 1-class build of dense_argmax.
module tb_dense_argmax;
    localparam int N = 128;

    logic           clk = 0;
    logic           rst_i = 1;
    logic           valid_i = 0;
    logic           ready_i = 0;
    logic           ready_o;
    logic           valid_o;
    logic [32*N-1:0] data_i = '0;
    logic [6:0]     class_o;
    logic [31:0]    max_o;

    logic           v1_i = 0;
    logic           r1_i = 0;
    logic           r1_o;
    logic           v1_o;
    logic [31:0]    d1_i = '0;
    logic [0:0]     c1_o;
    logic [31:0]    m1_o;

    int total = 0;
    int bad = 0;
    logic [32*N-1:0] vec;

    always #5 clk = ~clk;

    dense_argmax #(.BIAS(N)) u_dut (
        .clk(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .class_o(class_o), .max_o(max_o)
    );

    dense_argmax #(.BIAS(1)) u_dut1 (
        .clk(clk), .rst_i(rst_i), .valid_i(v1_i), .ready_o(r1_o), .data_i(d1_i),
        .valid_o(v1_o), .ready_i(r1_i), .class_o(c1_o), .max_o(m1_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32*N-1:0] fill(input logic [31:0] v);
        logic [32*N-1:0] r;
        for (int i = 0; i < N; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    task automatic wait_result(input string tag);
        int n;
        n = 1;
        while (!valid_o && n < 400) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, n, N);
    endtask

    task automatic release_result(input string tag);
        ready_i = 1;
        tick;
        ready_i = 0;
        check({tag, "_valid_drop"}, valid_o, 0);
        check({tag, "_ready_back"}, ready_o, 1);
    endtask

    task automatic run(input string tag, input logic [32*N-1:0] v, input logic [6:0] cls, input logic [31:0] mx);
        check({tag, "_ready_pre"}, ready_o, 1);
        data_i = v;
        valid_i = 1;
        tick;
        valid_i = 0;
        check({tag, "_busy"}, ready_o, 0);
        wait_result(tag);
        check({tag, "_class"}, class_o, cls);
        check({tag, "_max"}, max_o, mx);
        release_result(tag);
    endtask

    initial begin
        int seen;
        rst_i = 1;
        tick;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        tick;
        check("rst_class", class_o, 0);
        check("rst_max", max_o, 0);
        rst_i = 0;
        tick;
        check("idle_valid", valid_o, 0);
        check("idle_ready", ready_o, 1);
        check("idle_class", class_o, 0);
        check("idle_max", max_o, 0);

        vec = fill(32'h3F80_0000);
        vec[77*32 +: 32] = 32'h4000_0000;
        run("peak", vec, 77, 32'h4000_0000);

        vec = fill(32'hC000_0000);
        vec[5*32 +: 32]  = 32'hBF80_0000;
        vec[90*32 +: 32] = 32'hBF80_0000;
        vec[3*32 +: 32]  = 32'h8000_0000;
        run("negzero", vec, 3, 32'h8000_0000);

        vec = fill(32'hC000_0000);
        vec[3*32 +: 32] = 32'h0000_0000;
        vec[9*32 +: 32] = 32'h8000_0000;
        run("zerotie", vec, 3, 32'h0000_0000);

        vec = fill(32'h3F80_0000);
        vec[0*32 +: 32]  = 32'h7FC0_0000;
        vec[12*32 +: 32] = 32'h7F80_0000;
        run("inf", vec, 12, 32'h7F80_0000);

        run("allnan", fill(32'h7FC0_0000), 0, 32'h7FC0_0000);

        vec = fill(32'hBF80_0000);
        vec[10*32 +: 32] = 32'h0000_0001;
        vec[20*32 +: 32] = 32'h8000_0001;
        vec[30*32 +: 32] = 32'h0000_0000;
        run("denorm", vec, 10, 32'h0000_0001);

        vec = fill(32'h3F80_0000);
        vec[77*32 +: 32] = 32'h4000_0000;
        data_i = vec;
        valid_i = 1;
        tick;
        valid_i = 0;
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            tick;
            check("bp_valid", valid_o, 1);
            check("bp_ready", ready_o, 0);
            check("bp_class", class_o, 77);
            check("bp_max", max_o, 32'h4000_0000);
        end
        vec = fill(32'h3F80_0000);
        vec[127*32 +: 32] = 32'h3F80_0001;
        data_i = vec;
        valid_i = 1;
        ready_i = 1;
        tick;
        ready_i = 0;
        check("b2b_idle_ready", ready_o, 1);
        check("b2b_idle_valid", valid_o, 0);
        tick;
        valid_i = 0;
        check("b2b_accepted", ready_o, 0);
        wait_result("b2b");
        check("b2b_class", class_o, 127);
        check("b2b_max", max_o, 32'h3F80_0001);
        release_result("b2b");
        tick;
        check("hold_class", class_o, 127);
        check("hold_max", max_o, 32'h3F80_0001);

        vec = fill(32'h3F80_0000);
        vec[50*32 +: 32] = 32'h4000_0000;
        data_i = vec;
        valid_i = 1;
        tick;
        valid_i = 0;
        repeat (39) tick;
        rst_i = 1;
        tick;
        rst_i = 0;
        check("abort_ready", ready_o, 1);
        check("abort_class", class_o, 0);
        check("abort_max", max_o, 0);
        seen = 0;
        repeat (200) begin
            tick;
            if (valid_o) seen = 1;
        end
        check("abort_no_valid", seen, 0);
        run("after_abort", vec, 50, 32'h4000_0000);

        check("b1_ready", r1_o, 1);
        d1_i = 32'h4040_0000;
        v1_i = 1;
        tick;
        v1_i = 0;
        check("b1_latency", v1_o, 1);
        check("b1_class", c1_o, 0);
        check("b1_max", m1_o, 32'h4040_0000);
        r1_i = 1;
        tick;
        r1_i = 0;
        check("b1_valid_drop", v1_o, 0);
        check("b1_ready_back", r1_o, 1);
        d1_i = 32'h7FC0_0000;
        v1_i = 1;
        tick;
        v1_i = 0;
        check("b1_nan_valid", v1_o, 1);
        check("b1_nan_max", m1_o, 32'h7FC0_0000);
        r1_i = 1;
        tick;
        r1_i = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
